// File: rtl/img2col_mac_acc_pkg.sv
// Shared widths, types and default parameters for the img2col MAC accumulator.
// The width macros normally come from the shared define header. The guarded
// defaults below apply when that header is not in the build.
`ifndef ADDR_SIZE
`define ADDR_SIZE 16
`endif
`ifndef KERNEL_SIZE
`define KERNEL_SIZE 4
`endif
`ifndef CHANNELS_SIZE
`define CHANNELS_SIZE 8
`endif
`ifndef DATA_SIZE
`define DATA_SIZE 8
`endif
`ifndef PSUM_SIZE
`define PSUM_SIZE 32
`endif

package img2col_mac_acc_pkg;

  localparam int unsigned ADDR_W        = `ADDR_SIZE;
  localparam int unsigned K_W           = `KERNEL_SIZE;
  localparam int unsigned C_W           = `CHANNELS_SIZE;
  localparam int unsigned DATA_W_DEF    = `DATA_SIZE;
  localparam int unsigned PSUM_W_DEF    = `PSUM_SIZE;
  localparam int unsigned OUT_DEPTH_DEF = 8;
  localparam int unsigned NUM_W         = 16;
  // LEN = K*K*C needs the full product width of its factors
  localparam int unsigned LEN_W         = 2 * K_W + C_W;
  // Total pairs for a layer = LEN * num_psums
  localparam int unsigned TOT_W         = LEN_W + NUM_W;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CFG   = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Per-stage sideband carried alongside each operand pair
  typedef struct packed {
    logic vld;
    logic first;
    logic last;
  } tag_t;

endpackage

// File: rtl/img2col_mac_acc_psum_fifo.sv
// psum_fifo: synchronous FIFO for finished partial sums.
// The head value is held in a register, so o_data is a flop output.
// Ports: clk/rstn, i_push/i_data write side, i_pop read side,
//        o_data head value, o_valid not-empty, o_count occupancy.
module psum_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_valid,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             do_push_c, do_pop_c;
  logic [WIDTH-1:0] head_c;

  // Pointer/count update and next head value
  always_comb begin
    do_pop_c  = i_pop & (cnt_q != '0);
    // A full FIFO accepts a push only together with a pop
    do_push_c = i_push & ((cnt_q != CNT_W'(DEPTH)) | do_pop_c);
    wr_d      = do_push_c ? wr_q + PTR_W'(1) : wr_q;
    rd_d      = do_pop_c  ? rd_q + PTR_W'(1) : rd_q;
    cnt_d     = cnt_q + CNT_W'(do_push_c) - CNT_W'(do_pop_c);
    // The entry being written this edge becomes the head when it lands on rd_d
    head_c    = (do_push_c && (wr_q == rd_d)) ? i_data : mem_q[rd_d];
    data_d    = (cnt_d != '0) ? head_c : data_q;
    valid_d   = (cnt_d != '0);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  // Storage array, no reset needed: contents are only read once written
  always_ff @(posedge clk) begin
    if (do_push_c) mem_q[wr_q] <= i_data;
  end

  assign o_data  = data_q;
  assign o_valid = valid_q;
  assign o_count = cnt_q;

endmodule

// File: rtl/img2col_mac_acc.sv
// img2col_mac_acc: consumes tensor/weight address pairs, reads both SRAMs,
// multiplies and accumulates LEN = K*K*C products per partial sum and queues
// each sum in an output FIFO. Throttles the address generators via o_addr_en.
// Optional feature macro MAC_RELU_EN: clamp negative sums to 0 before queueing.
// Ports:
//   clk, rstn                      clock, async active-low reset
//   i_start, kernel_size, channels, i_num_psums   layer configuration
//   o_addr_en, i_addr_valid, i_tensor_addr, i_weight_addr   address input
//   o_t_rd_en/o_t_rd_addr/i_t_rd_data             tensor SRAM (1-cycle read)
//   o_w_rd_en/o_w_rd_addr/i_w_rd_data             weight SRAM (1-cycle read)
//   o_psum, o_psum_valid, i_psum_ready            output stream
//   o_busy, o_done                                status
module img2col_mac_acc
  import img2col_mac_acc_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned PSUM_W    = PSUM_W_DEF,
  parameter int unsigned OUT_DEPTH = OUT_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_start,
  input  logic [K_W-1:0]    kernel_size,
  input  logic [C_W-1:0]    channels,
  input  logic [NUM_W-1:0]  i_num_psums,
  output logic              o_addr_en,
  input  logic              i_addr_valid,
  input  logic [ADDR_W-1:0] i_tensor_addr,
  input  logic [ADDR_W-1:0] i_weight_addr,
  output logic              o_t_rd_en,
  output logic [ADDR_W-1:0] o_t_rd_addr,
  input  logic [DATA_W-1:0] i_t_rd_data,
  output logic              o_w_rd_en,
  output logic [ADDR_W-1:0] o_w_rd_addr,
  input  logic [DATA_W-1:0] i_w_rd_data,
  output logic [PSUM_W-1:0] o_psum,
  output logic              o_psum_valid,
  input  logic              i_psum_ready,
  output logic              o_busy,
  output logic              o_done
);

  localparam int unsigned CNT_W = $clog2(OUT_DEPTH) + 1;
  localparam int unsigned MUL_W = 2 * DATA_W;

  state_e              state_q, state_d;
  logic [K_W-1:0]      k_q, k_d;
  logic [C_W-1:0]      c_q, c_d;
  logic [NUM_W-1:0]    num_q, num_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [TOT_W-1:0]    left_q, left_d;
  logic [LEN_W-1:0]    elem_q, elem_d;
  logic [NUM_W-1:0]    popped_q, popped_d;
  logic                addr_en_q, addr_en_d;
  tag_t                s0_q, s0_d;
  logic [ADDR_W-1:0]   t_addr_q, t_addr_d;
  logic [ADDR_W-1:0]   w_addr_q, w_addr_d;
  tag_t                p_q, p_d;
  logic [PSUM_W-1:0]   prod_q, prod_d;
  logic [PSUM_W-1:0]   acc_q, acc_d;
  logic                acc_last_q, acc_last_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                accept_c, pop_c, push_c, last_c, pipe_empty_c;
  logic [LEN_W-1:0]    len_c;
  logic signed [MUL_W-1:0] mul_c;
  logic [PSUM_W-1:0]   push_data_c;
  logic [CNT_W-1:0]    fifo_cnt, cnt_nxt_c, free_c;
  logic                fifo_valid;

  // Next-state, pipeline and output computation
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    c_d        = c_q;
    num_d      = num_q;
    len_d      = len_q;
    left_d     = left_q;
    elem_d     = elem_q;
    popped_d   = popped_q;
    s0_d       = '0;
    t_addr_d   = t_addr_q;
    w_addr_d   = w_addr_q;
    p_d        = s0_q;
    prod_d     = prod_q;
    acc_d      = acc_q;
    acc_last_d = 1'b0;

    accept_c     = addr_en_q & i_addr_valid;
    pop_c        = fifo_valid & i_psum_ready;
    push_c       = acc_last_q;
    len_c        = LEN_W'(k_q) * LEN_W'(k_q) * LEN_W'(c_q);
    last_c       = (elem_q == len_q - LEN_W'(1));
    pipe_empty_c = ~s0_q.vld & ~p_q.vld & ~acc_last_q;
    mul_c        = MUL_W'($signed(i_t_rd_data)) * MUL_W'($signed(i_w_rd_data));

`ifdef MAC_RELU_EN
    push_data_c = acc_q[PSUM_W-1] ? '0 : acc_q;
`else
    push_data_c = acc_q;
`endif

    if (pop_c) popped_d = popped_q + NUM_W'(1);

    // S0: register strobes/addresses and tag the pair's position in its dot product
    if (accept_c) begin
      left_d     = left_q - TOT_W'(1);
      elem_d     = last_c ? '0 : elem_q + LEN_W'(1);
      s0_d.vld   = 1'b1;
      s0_d.first = (elem_q == '0);
      s0_d.last  = last_c;
      t_addr_d   = i_tensor_addr;
      w_addr_d   = i_weight_addr;
    end

    // S2: signed product of the returned SRAM data
    if (s0_q.vld) prod_d = PSUM_W'(mul_c);

    // S3: first product loads, the rest accumulate
    if (p_q.vld) begin
      acc_d      = p_q.first ? prod_q : acc_q + prod_q;
      acc_last_d = p_q.last;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          k_d      = kernel_size;
          c_d      = channels;
          num_d    = i_num_psums;
          popped_d = '0;
          elem_d   = '0;
          state_d  = ST_CFG;
        end
      end
      ST_CFG: begin
        len_d   = len_c;
        left_d  = TOT_W'(len_c) * TOT_W'(num_q);
        state_d = ((len_c == '0) || (num_q == '0)) ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        if (left_q == '0) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (pipe_empty_c && (popped_q == num_q)) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Enable is registered from next-cycle values; free space ignores up to
    // three pairs still in the pipeline, which the >3 margin covers.
    cnt_nxt_c = fifo_cnt + CNT_W'(push_c) - CNT_W'(pop_c);
    free_c    = CNT_W'(OUT_DEPTH) - cnt_nxt_c;
    addr_en_d = (state_d == ST_RUN) && (free_c > CNT_W'(3)) && (left_d != '0);
    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      k_q        <= '0;
      c_q        <= '0;
      num_q      <= '0;
      len_q      <= '0;
      left_q     <= '0;
      elem_q     <= '0;
      popped_q   <= '0;
      addr_en_q  <= 1'b0;
      s0_q       <= '0;
      t_addr_q   <= '0;
      w_addr_q   <= '0;
      p_q        <= '0;
      prod_q     <= '0;
      acc_q      <= '0;
      acc_last_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      c_q        <= c_d;
      num_q      <= num_d;
      len_q      <= len_d;
      left_q     <= left_d;
      elem_q     <= elem_d;
      popped_q   <= popped_d;
      addr_en_q  <= addr_en_d;
      s0_q       <= s0_d;
      t_addr_q   <= t_addr_d;
      w_addr_q   <= w_addr_d;
      p_q        <= p_d;
      prod_q     <= prod_d;
      acc_q      <= acc_d;
      acc_last_q <= acc_last_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  psum_fifo #(
    .WIDTH (PSUM_W),
    .DEPTH (OUT_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .i_push  (push_c),
    .i_data  (push_data_c),
    .i_pop   (pop_c),
    .o_data  (o_psum),
    .o_valid (fifo_valid),
    .o_count (fifo_cnt)
  );

  assign o_psum_valid = fifo_valid;
  assign o_addr_en    = addr_en_q;
  assign o_t_rd_en    = s0_q.vld;
  assign o_w_rd_en    = s0_q.vld;
  assign o_t_rd_addr  = t_addr_q;
  assign o_w_rd_addr  = w_addr_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;

endmodule

// File: tb/tb_img2col_mac_acc.sv
// Testbench for img2col_mac_acc: SRAM and address-generator models driven per
// cycle, expected partial sums computed from the accepted address pairs.
module tb_img2col_mac_acc;
  import img2col_mac_acc_pkg::*;

  logic              clk = 1'b0;
  logic              rstn = 1'b1;
  logic              i_start = 1'b0;
  logic [K_W-1:0]    kernel_size = '0;
  logic [C_W-1:0]    channels = '0;
  logic [NUM_W-1:0]  i_num_psums = '0;
  logic              o_addr_en;
  logic              i_addr_valid = 1'b0;
  logic [ADDR_W-1:0] i_tensor_addr = '0;
  logic [ADDR_W-1:0] i_weight_addr = '0;
  logic              o_t_rd_en;
  logic [ADDR_W-1:0] o_t_rd_addr;
  logic [7:0]        i_t_rd_data = '0;
  logic              o_w_rd_en;
  logic [ADDR_W-1:0] o_w_rd_addr;
  logic [7:0]        i_w_rd_data = '0;
  logic [31:0]       o_psum;
  logic              o_psum_valid;
  logic              i_psum_ready = 1'b0;
  logic              o_busy;
  logic              o_done;

  img2col_mac_acc #(.DATA_W(8), .PSUM_W(32), .OUT_DEPTH(8)) dut (
    .clk(clk), .rstn(rstn), .i_start(i_start), .kernel_size(kernel_size),
    .channels(channels), .i_num_psums(i_num_psums), .o_addr_en(o_addr_en),
    .i_addr_valid(i_addr_valid), .i_tensor_addr(i_tensor_addr),
    .i_weight_addr(i_weight_addr), .o_t_rd_en(o_t_rd_en), .o_t_rd_addr(o_t_rd_addr),
    .i_t_rd_data(i_t_rd_data), .o_w_rd_en(o_w_rd_en), .o_w_rd_addr(o_w_rd_addr),
    .i_w_rd_data(i_w_rd_data), .o_psum(o_psum), .o_psum_valid(o_psum_valid),
    .i_psum_ready(i_psum_ready), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  logic signed [7:0]  tmem [256];
  logic signed [7:0]  wmem [256];
  logic signed [31:0] exp_q [$];
  logic signed [31:0] sum_m;
  logic [31:0]        last_psum;
  int n_assert = 0, n_fail = 0;
  int cyc_no = 0, start_cyc = 0, done_cyc = 0;
  int len_m = 0, elem_m = 0, groups_acc = 0, popped = 0;
  int done_seen = 0, reads_seen = 0, max_pending = 0;
  int vprob = 0, rprob = 0, lat_start = 0;
  bit lat_en = 1'b0, prev_valid = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, expv, expv);
    end
  endtask

  function automatic logic signed [31:0] relu(input logic signed [31:0] v);
`ifdef MAC_RELU_EN
    return (v < 0) ? 32'sd0 : v;
`else
    return v;
`endif
  endfunction

  task automatic fill(input int t, input int w);
    for (int i = 0; i < 256; i++) begin tmem[i] = 8'(t); wmem[i] = 8'(w); end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 256; i++) begin tmem[i] = 8'($urandom); wmem[i] = 8'($urandom); end
  endtask

  // One clock cycle: act on the falling edge, DUT samples at the next rising edge
  task automatic cyc();
    logic signed [31:0] prod;
    @(negedge clk);
    cyc_no++;
    if (o_done) begin
      if (done_seen == 0) done_cyc = cyc_no;
      done_seen++;
    end
    if (o_t_rd_en) begin
      reads_seen++;
      i_t_rd_data = tmem[o_t_rd_addr[7:0]];
    end else i_t_rd_data = 8'($urandom);
    i_w_rd_data = o_w_rd_en ? wmem[o_w_rd_addr[7:0]] : 8'($urandom);
    if (lat_en && o_psum_valid && !prev_valid) check("latency", 32'(cyc_no - lat_start), 32'd4);
    prev_valid = o_psum_valid;
    i_psum_ready = (int'($urandom_range(99)) < rprob);
    if (o_psum_valid && i_psum_ready) begin
      if (exp_q.size() == 0) check("unexpected_psum", 32'd1, 32'd0);
      else check("psum", o_psum, exp_q.pop_front());
      last_psum = o_psum;
      popped++;
    end
    i_addr_valid  = (int'($urandom_range(99)) < vprob);
    i_tensor_addr = ADDR_W'($urandom);
    i_weight_addr = ADDR_W'($urandom);
    if (o_addr_en && i_addr_valid) begin
      prod  = 32'(tmem[i_tensor_addr[7:0]]) * 32'(wmem[i_weight_addr[7:0]]);
      sum_m = (elem_m == 0) ? prod : sum_m + prod;
      elem_m++;
      if (elem_m == len_m) begin
        exp_q.push_back(relu(sum_m));
        elem_m = 0;
        groups_acc++;
        lat_start = cyc_no;
      end
    end
    if (groups_acc - popped > max_pending) max_pending = groups_acc - popped;
  endtask

  task automatic start_layer(input int k, input int c, input int num);
    len_m = k * k * c; elem_m = 0; groups_acc = 0; popped = 0;
    done_seen = 0; reads_seen = 0; max_pending = 0; exp_q.delete();
    kernel_size = K_W'(k); channels = C_W'(c); i_num_psums = NUM_W'(num);
    start_cyc = cyc_no;
    i_start = 1'b1;
    cyc();
    i_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int num, input int budget);
    int n = 0;
    int exp_n = (len_m == 0) ? 0 : num;
    while (done_seen == 0 && n < budget) begin cyc(); n++; end
    check({tag, " timeout"}, 32'(n >= budget), 32'd0);
    repeat (3) cyc();
    check({tag, " done_once"}, 32'(done_seen), 32'd1);
    check({tag, " popped"}, 32'(popped), 32'(exp_n));
    check({tag, " groups"}, 32'(groups_acc), 32'(exp_n));
    check({tag, " reads"}, 32'(reads_seen), 32'(len_m * num));
    check({tag, " busy"}, 32'(o_busy), 32'd0);
  endtask

  initial begin
    // Reset state
    #2 rstn = 1'b0;
    repeat (2) cyc();
    check("rst addr_en", 32'(o_addr_en), 0);
    check("rst t_rd_en", 32'(o_t_rd_en), 0);
    check("rst psum_valid", 32'(o_psum_valid), 0);
    check("rst psum", o_psum, 0);
    check("rst busy", 32'(o_busy), 0);
    check("rst done", 32'(o_done), 0);
    rstn = 1'b1;
    repeat (2) cyc();

    // 1: LEN=1, t=3 w=-2
    fill(3, -2); vprob = 100; rprob = 100;
    start_layer(1, 1, 4);
    wait_done("t1", 4, 500);
    check("t1 value", last_psum, relu(-32'sd6));

    // 2: LEN=18 all ones, latency to first valid
    fill(1, 1); lat_en = 1'b1;
    start_layer(3, 2, 2);
    wait_done("t2", 2, 500);
    lat_en = 1'b0;
    check("t2 value", last_psum, 32'd18);

    // 3: consumer stalled, FIFO fills to depth, then drains in order
    fill_rand(); vprob = 100; rprob = 0;
    start_layer(1, 1, 12);
    repeat (30) cyc();
    check("t3 peak", 32'(max_pending), 32'd8);
    check("t3 addr_en low", 32'(o_addr_en), 0);
    check("t3 valid", 32'(o_psum_valid), 1);
    check("t3 hold a", o_psum, exp_q[0]);
    cyc();
    check("t3 hold b", o_psum, exp_q[0]);
    rprob = 100;
    wait_done("t3", 12, 500);

    // 4: operand extremes
    fill(-128, -128); vprob = 100; rprob = 100;
    start_layer(1, 2, 2);
    wait_done("t4a", 2, 500);
    check("t4a value", last_psum, 32'd32768);
    fill(127, -128);
    start_layer(1, 1, 2);
    wait_done("t4b", 2, 500);
    check("t4b value", last_psum, relu(-32'sd16256));

    // 5: reset in the middle of a layer
    fill_rand(); vprob = 100; rprob = 100;
    start_layer(3, 2, 4);
    repeat (15) cyc();
    check("t5 busy before", 32'(o_busy), 1);
    rstn = 1'b0;
    #1;
    check("t5 addr_en", 32'(o_addr_en), 0);
    check("t5 rd_en", 32'(o_t_rd_en | o_w_rd_en), 0);
    check("t5 psum_valid", 32'(o_psum_valid), 0);
    check("t5 psum", o_psum, 0);
    check("t5 busy", 32'(o_busy), 0);
    cyc();
    rstn = 1'b1;
    done_seen = 0;
    repeat (10) cyc();
    check("t5 no done", 32'(done_seen), 0);
    check("t5 idle", 32'(o_busy), 0);
    vprob = 70; rprob = 60;
    start_layer(2, 3, 3);
    wait_done("t5 restart", 3, 2000);

    // 6: zero psums and zero LEN skip straight to DONE
    start_layer(2, 2, 0);
    wait_done("t6", 0, 50);
    check("t6 done latency", 32'(done_cyc - start_cyc), 32'd2);
    start_layer(2, 0, 3);
    wait_done("t6 len0", 3, 50);
    check("t6 len0 latency", 32'(done_cyc - start_cyc), 32'd2);

    // Randomized layers
    for (int r = 0; r < 4; r++) begin
      int k = int'($urandom_range(3, 1));
      int c = int'($urandom_range(3, 1));
      int num = int'($urandom_range(5, 1));
      fill_rand();
      vprob = int'($urandom_range(100, 40));
      rprob = int'($urandom_range(100, 30));
      start_layer(k, c, num);
      wait_done("rand", num, 5000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
